// File: rtl/core_gray_if.sv
// Signal bundle for core_gray_engine: run control, image-memory ports and status.
// The cycle_cnt member exists only when CORE_CYCLE_CNT_EN is defined.
interface core_gray_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 32
);
  logic              start;
  logic              pause;
  logic              abort;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] num_pixels;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [PIX_W-1:0]  mem_wr_data;
  logic [2:0]        state;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [ADDR_W-1:0] pixels_done;
`ifdef CORE_CYCLE_CNT_EN
  logic [31:0]       cycle_cnt;

  modport master (
    input  start, pause, abort, mode, num_pixels, mem_rd_data,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output state, busy, done, aborted, pixels_done, cycle_cnt
  );

  modport slave (
    output start, pause, abort, mode, num_pixels, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  state, busy, done, aborted, pixels_done, cycle_cnt
  );
`else
  modport master (
    input  start, pause, abort, mode, num_pixels, mem_rd_data,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output state, busy, done, aborted, pixels_done
  );

  modport slave (
    output start, pause, abort, mode, num_pixels, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  state, busy, done, aborted, pixels_done
  );
`endif
endinterface

// File: rtl/core_gray_engine.sv
// RGB-to-grayscale core: 7-cycle read/convert/write sequence per pixel with pause/abort.
// Optional cycle counter output enabled by defining CORE_CYCLE_CNT_EN.
module core_gray_engine #(
  parameter int              PIX_W      = 8,
  parameter int              IMG_PIXELS = 40960,
  parameter int              ADDR_W     = 32,
  parameter longint unsigned IN_BASE    = 0,
  parameter longint unsigned OUT_BASE   = IN_BASE + 64'(3) * 64'(IMG_PIXELS)
) (
  input  logic         clk,
  input  logic         rst_n,
  core_gray_if.master  bus
);

  typedef enum logic [2:0] {
    core_reset          = 3'd0,
    core_wait_for_start = 3'd1,
    core_processing     = 3'd2,
    core_pause          = 3'd3,
    core_abort          = 3'd4,
    core_done           = 3'd5
  } core_states;

  localparam int                WW         = PIX_W + 10;
  localparam logic [ADDR_W-1:0] IMG_N      = ADDR_W'(IMG_PIXELS);
  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
  localparam longint unsigned   LAST_BYTE  = OUT_BASE + 64'(3) * 64'(IMG_PIXELS) - 64'd1;

  if (PIX_W < 4 || PIX_W > 16) begin : g_bad_pix_w
    $error("core_gray_engine: PIX_W must be within 4..16");
  end
  if (ADDR_W < 64) begin : g_addr_chk
    if (LAST_BYTE >= (64'd1 << ADDR_W)) begin : g_bad_region
      $error("core_gray_engine: output region does not fit in ADDR_W address bits");
    end
  end

  function automatic logic [PIX_W-1:0] sat_pix(input logic [WW-1:0] v);
    return (|v[WW-1:PIX_W]) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] gray_of(input logic [PIX_W-1:0] r,
                                               input logic [PIX_W-1:0] g,
                                               input logic [PIX_W-1:0] b,
                                               input logic [1:0]       m);
    logic [WW-1:0] rw, gw, bw, mx, mn, acc;
    rw = WW'(r);
    gw = WW'(g);
    bw = WW'(b);
    mx = rw;
    if (gw > mx) mx = gw;
    if (bw > mx) mx = bw;
    mn = rw;
    if (gw < mn) mn = gw;
    if (bw < mn) mn = bw;
    case (m)
      2'd0:    acc = (rw + gw + bw) / WW'(3);
      2'd1:    acc = (mx + mn) >> 1;
      2'd2:    acc = (WW'(77) * rw + WW'(150) * gw + WW'(29) * bw) >> 8;
      default: acc = gw;
    endcase
    return sat_pix(acc);
  endfunction

  core_states        state_q, state_d;
  logic [2:0]        phase_q;
  logic [ADDR_W-1:0] eff_n_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [ADDR_W-1:0] in_ptr_q;
  logic [ADDR_W-1:0] out_ptr_q;
  logic [1:0]        mode_q;
  logic              aborted_q;
  logic [PIX_W-1:0]  r_p1, g_p2, gray_p3;

  logic              idle_or_done;
  logic              launch;
  logic              active;
  logic              abort_hit;
  logic              last_pix;
  logic [ADDR_W-1:0] num_eff;

  assign idle_or_done = (state_q == core_wait_for_start) || (state_q == core_done);
  assign launch       = idle_or_done && bus.start;
  assign active       = (state_q == core_processing) || (state_q == core_pause);
  assign abort_hit    = active && bus.abort;
  assign last_pix     = (pix_cnt_q + ADDR_W'(1)) == eff_n_q;
  assign num_eff      = (bus.num_pixels > IMG_N) ? IMG_N : bus.num_pixels;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= core_reset;
    else        state_q <= state_d;
  end

  // Abort outranks completion; completion outranks a pause request at the boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      core_reset:          state_d = core_wait_for_start;
      core_wait_for_start,
      core_done: begin
        if (bus.start) state_d = (num_eff == '0) ? core_done : core_processing;
      end
      core_processing: begin
        if (bus.abort)              state_d = core_abort;
        else if (phase_q == 3'd6) begin
          if (last_pix)             state_d = core_done;
          else if (bus.pause)       state_d = core_pause;
        end
      end
      core_pause: begin
        if (bus.abort)              state_d = core_abort;
        else if (!bus.pause)        state_d = core_processing;
      end
      core_abort:          state_d = core_wait_for_start;
      default:             state_d = core_reset;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      eff_n_q   <= '0;
      pix_cnt_q <= '0;
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      mode_q    <= '0;
      aborted_q <= 1'b0;
    end else if (launch) begin
      phase_q   <= '0;
      eff_n_q   <= num_eff;
      pix_cnt_q <= '0;
      in_ptr_q  <= IN_BASE_A;
      out_ptr_q <= OUT_BASE_A;
      mode_q    <= bus.mode;
      aborted_q <= 1'b0;
    end else if (abort_hit) begin
      aborted_q <= 1'b1;
    end else if (state_q == core_processing) begin
      if (phase_q == 3'd6) begin
        phase_q   <= '0;
        pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
        in_ptr_q  <= in_ptr_q + ADDR_W'(3);
        out_ptr_q <= out_ptr_q + ADDR_W'(3);
      end else begin
        phase_q   <= phase_q + 3'd1;
      end
    end
  end

  // p1/p2: channel captures one cycle after each read; p3: gray from R, G and live B.
  always_ff @(posedge clk) begin
    if (state_q == core_processing) begin
      if (phase_q == 3'd1) r_p1    <= bus.mem_rd_data;
      if (phase_q == 3'd2) g_p2    <= bus.mem_rd_data;
      if (phase_q == 3'd3) gray_p3 <= gray_of(r_p1, g_p2, bus.mem_rd_data, mode_q);
    end
  end

`ifdef CORE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cycle_cnt_q <= '0;
    else if (launch)                      cycle_cnt_q <= '0;
    else if (active && !(&cycle_cnt_q))   cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`endif

  logic rd_on, wr_on;

  // Strobes decode straight from the state register so reset clears them asynchronously.
  assign rd_on = (state_q == core_processing) && (phase_q <= 3'd2);
  assign wr_on = (state_q == core_processing) && (phase_q >= 3'd4) && (phase_q <= 3'd6);

  assign bus.mem_rd_en   = rd_on;
  assign bus.mem_rd_addr = rd_on ? (in_ptr_q + ADDR_W'(phase_q)) : '0;
  assign bus.mem_wr_en   = wr_on;
  assign bus.mem_wr_addr = wr_on ? (out_ptr_q + ADDR_W'(phase_q - 3'd4)) : '0;
  assign bus.mem_wr_data = wr_on ? gray_p3 : '0;

  assign bus.state       = state_q;
  assign bus.busy        = active;
  assign bus.done        = (state_q == core_done);
  assign bus.aborted     = aborted_q;
  assign bus.pixels_done = pix_cnt_q;

endmodule

// File: tb/tb_core_gray_engine.sv
// Directed plus randomized bench for core_gray_engine against a pixel-level reference model.
module tb_core_gray_engine;

  localparam int IMG   = 16;
  localparam int IN_B  = 16;
  localparam int OUT_B = IN_B + 3 * IMG;

  localparam int S_RESET = 0, S_WAIT = 1, S_PROC = 2, S_PAUSE = 3, S_ABORT = 4, S_DONE = 5;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   rd_cnt;
  wr_t  wq[$];
  logic [7:0] mem [0:255];
  int   cur_mode;

  core_gray_if #(.PIX_W(8), .ADDR_W(32)) bus ();

  core_gray_engine #(
    .PIX_W(8), .IMG_PIXELS(IMG), .ADDR_W(32), .IN_BASE(IN_B), .OUT_BASE(OUT_B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data one cycle after the strobe; writes are logged.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= mem[bus.mem_rd_addr[7:0]];
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.mem_wr_en) wq.push_back('{int'(bus.mem_wr_addr), int'(bus.mem_wr_data)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_gray(int r, int g, int b, int m);
    int mx, mn, v;
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;
    mn = (mn < b) ? mn : b;
    case (m)
      0:       v = (r + g + b) / 3;
      1:       v = (mx + mn) / 2;
      2:       v = (77 * r + 150 * g + 29 * b) / 256;
      default: v = g;
    endcase
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic int wr_data_at(int i);
    return (i < wq.size()) ? wq[i].data : -1;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < 3 * n; i++) mem[IN_B + i] = 8'($urandom);
  endtask

  task automatic set_pixel(input int i, input int r, input int g, input int b);
    mem[IN_B + 3 * i]     = 8'(r);
    mem[IN_B + 3 * i + 1] = 8'(g);
    mem[IN_B + 3 * i + 2] = 8'(b);
  endtask

  task automatic start_run(input int n, input int m);
    cur_mode       = m;
    bus.mode       = 2'(m);
    bus.num_pixels = 32'(n);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.mode       = 2'($urandom);
  endtask

  task automatic wait_done(input int exp_cycles, input bit poke_start, input string tag);
    int cyc;
    cyc = 0;
    while (bus.state == 3'(S_PROC) && cyc < 2000) begin
      bus.start = poke_start && (cyc == 5);
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " cycles"}, cyc, exp_cycles);
    check({tag, " state"}, bus.state, S_DONE);
    check({tag, " done"}, bus.done, 1);
  endtask

  task automatic verify_writes(input int wbase, input int eff, input string tag);
    check({tag, " wr count"}, wq.size() - wbase, 3 * eff);
    check({tag, " pixels_done"}, bus.pixels_done, eff);
    for (int i = 0; i < eff; i++) begin
      int exp_g;
      exp_g = ref_gray(mem[IN_B + 3 * i], mem[IN_B + 3 * i + 1], mem[IN_B + 3 * i + 2], cur_mode);
      for (int k = 0; k < 3; k++) begin
        if (wbase + 3 * i + k < wq.size()) begin
          check($sformatf("%s wr addr %0d", tag, 3 * i + k), wq[wbase + 3 * i + k].addr, OUT_B + 3 * i + k);
          check($sformatf("%s wr data %0d", tag, 3 * i + k), wq[wbase + 3 * i + k].data, exp_g);
        end
      end
    end
  endtask

  task automatic run_and_check(input int n, input int m, input bit poke_start, input string tag);
    int eff, wbase, rbase;
    eff   = (n > IMG) ? IMG : n;
    wbase = wq.size();
    rbase = rd_cnt;
    start_run(n, m);
    check({tag, " state after start"}, bus.state, (eff == 0) ? S_DONE : S_PROC);
    check({tag, " aborted cleared"}, bus.aborted, 0);
    wait_done(7 * eff, poke_start, tag);
    check({tag, " rd count"}, rd_cnt - rbase, 3 * eff);
    verify_writes(wbase, eff, tag);
  endtask

  initial begin
    int wbase, cnt;
    tests = 0;
    fails = 0;
    rd_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    bus.mode = 2'd0;
    bus.num_pixels = '0;
    bus.mem_rd_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    repeat (3) tick();
    check("reset state", bus.state, S_RESET);
    check("reset rd_en", bus.mem_rd_en, 0);
    check("reset wr_en", bus.mem_wr_en, 0);
    check("reset rd_addr", bus.mem_rd_addr, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset aborted", bus.aborted, 0);
    check("reset pixels_done", bus.pixels_done, 0);
    rst_n = 1'b1;
    tick();
    check("wait after release", bus.state, S_WAIT);

    // Abort outside a run is ignored.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle abort state", bus.state, S_WAIT);
    check("idle abort flag", bus.aborted, 0);

    set_pixel(0, 30, 60, 90);
    set_pixel(1, 255, 255, 254);
    wbase = wq.size();
    run_and_check(2, 0, 1'b0, "avg2");
    check("avg2 px0 value", wr_data_at(wbase), 60);
    check("avg2 px1 value", wr_data_at(wbase + 3), 254);

    set_pixel(0, 255, 255, 255);
    wbase = wq.size();
    run_and_check(1, 2, 1'b0, "lum white");
    check("lum white value", wr_data_at(wbase), 255);

    set_pixel(0, 10, 200, 50);
    wbase = wq.size();
    run_and_check(1, 1, 1'b0, "light");
    check("light value", wr_data_at(wbase), 105);

    set_pixel(0, 1, 2, 3);
    wbase = wq.size();
    run_and_check(1, 3, 1'b0, "green");
    check("green value", wr_data_at(wbase), 2);

    run_and_check(0, 0, 1'b0, "zero");

    for (int r = 0; r < 6; r++) begin
      fill_random(6);
      run_and_check($urandom_range(1, 6), $urandom_range(0, 3), r == 2, $sformatf("rand%0d", r));
    end

    fill_random(IMG);
    wbase = wq.size();
    run_and_check(IMG + 5, $urandom_range(0, 3), 1'b1, "clamp");
    check("clamp last addr", (wq.size() > 0) ? wq[wq.size() - 1].addr : -1, OUT_B + 3 * IMG - 1);

    // Pause raised in P2 of pixel 0, held for ten pause cycles.
    fill_random(3);
    wbase = wq.size();
    start_run(3, $urandom_range(0, 3));
    tick();
    tick();
    check("pause P2 rd_addr", bus.mem_rd_addr, IN_B + 2);
    bus.pause = 1'b1;
    cnt = 0;
    while (bus.state != 3'(S_PAUSE) && cnt < 20) begin
      tick();
      cnt++;
    end
    check("pause entry ticks", cnt, 5);
    check("pause px0 writes", wq.size() - wbase, 3);
    cnt = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.state == 3'(S_PAUSE) && !bus.mem_rd_en && !bus.mem_wr_en) cnt++;
    end
    bus.pause = 1'b0;
    tick();
    check("pause idle cycles", cnt, 10);
    check("resume state", bus.state, S_PROC);
    check("resume rd_en", bus.mem_rd_en, 1);
    check("resume rd_addr", bus.mem_rd_addr, IN_B + 3);
    wait_done(14, 1'b0, "pause");
    verify_writes(wbase, 3, "pause");

    // Abort in P5 of pixel 3.
    fill_random(6);
    wbase = wq.size();
    start_run(6, $urandom_range(0, 3));
    repeat (26) tick();
    check("abort P5 wr_en", bus.mem_wr_en, 1);
    check("abort P5 wr_addr", bus.mem_wr_addr, OUT_B + 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort state", bus.state, S_ABORT);
    check("abort wr_en", bus.mem_wr_en, 0);
    check("abort aborted", bus.aborted, 1);
    check("abort pixels_done", bus.pixels_done, 3);
    check("abort writes", wq.size() - wbase, 11);
    tick();
    check("abort to wait", bus.state, S_WAIT);
    check("abort sticky", bus.aborted, 1);
    fill_random(1);
    run_and_check(1, $urandom_range(0, 3), 1'b0, "post abort");

    // Asynchronous reset in P4.
    fill_random(2);
    start_run(2, 0);
    repeat (4) tick();
    check("rst P4 wr_en before", bus.mem_wr_en, 1);
    rst_n = 1'b0;
    #2;
    check("async rst state", bus.state, S_RESET);
    check("async rst wr_en", bus.mem_wr_en, 0);
    check("async rst wr_addr", bus.mem_wr_addr, 0);
    check("async rst wr_data", bus.mem_wr_data, 0);
    check("async rst pixels_done", bus.pixels_done, 0);
    check("async rst busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post rst wait", bus.state, S_WAIT);

    fill_random(3);
    run_and_check(3, $urandom_range(0, 3), 1'b0, "three");
`ifdef CORE_CYCLE_CNT_EN
    check("cycle_cnt 3px", bus.cycle_cnt, 21);
    repeat (3) tick();
    check("cycle_cnt frozen", bus.cycle_cnt, 21);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_gray_engine.md
Name: core_gray_engine

Overview:
- Parametrised RGB-to-grayscale processing core.
- Reads interleaved R,G,B bytes from the input image region of the core image memory and converts each pixel with a runtime-selectable method.
- Writes the gray value to all three channel bytes of the processed image region.
- Generalises the fixed 8-bit, fixed-size core: pixel width, image size, base addresses and conversion mode are configurable. Adds pause/resume/abort control and progress reporting.

Parameters:
- PIX_W, 8, bits per colour channel (4..16)
- IMG_PIXELS, 40960, maximum pixels per image (40*1024)
- ADDR_W, 32, memory address width
- IN_BASE, 0, byte address of the first R byte in the input region
- OUT_BASE, IN_BASE+3*IMG_PIXELS, byte address of the first processed byte

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; starts a run from core_wait_for_start or core_done
- pause  in  1  level; requests a pause at the next pixel boundary
- abort  in  1  pulse; terminates the run
- mode  in  2  0=average, 1=lightness, 2=luminosity, 3=green-only
- num_pixels  in  ADDR_W  pixels to process; latched at start
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  PIX_W  write data
- state  out  3  current state, encoded as core_states (core_reset=0 .. core_done=5)
- busy  out  1  high in core_processing and core_pause
- done  out  1  high while in core_done
- aborted  out  1  sticky; set on abort, cleared on next start
- pixels_done  out  ADDR_W  count of completed pixels (all three writes issued)

Behaviour:
- Reset (async assert, sync release): state=core_reset, all strobes/addresses/data=0, done=0, busy=0, aborted=0, pixels_done=0. First clock after release moves to core_wait_for_start.
- core_wait_for_start / core_done + start=1:
  - latch mode and eff_n = min(num_pixels, IMG_PIXELS); clear pixels_done and aborted.
  - If eff_n==0 go directly to core_done, otherwise go to core_processing.
  - In core_done with start held high, a new run begins immediately. Bench must drop start to avoid repeats.
- Per-pixel micro-sequence for pixel i (phase 0..6, 7 cycles/pixel, no overlap):
  - P0: rd R at IN_BASE+3i.
  - P1: rd G at +1; capture R.
  - P2: rd B at +2; capture G.
  - P3: capture B; register gray.
  - P4/P5/P6: wr gray to OUT_BASE+3i, +1, +2.
  - pixels_done increments in the cycle after P6.
- Gray arithmetic (exact, unsigned, floor):
  - mode0: (R+G+B)/3.
  - mode1: (max+min)>>1.
  - mode2: (77R+150G+29B)>>8. Internal width ≥ PIX_W+8; result saturates at 2^PIX_W-1.
  - mode3: G.
- Pause:
  - sampled only at a pixel boundary (after P6). If pause=1, go to core_pause with strobes low.
  - core_pause → core_processing on the first cycle pause=0; resume at P0 of the next pixel.
- Completion: after P6 of pixel eff_n-1, go to core_done. Hold there; no strobes.
- Abort:
  - takes priority over pause and completion. In core_processing or core_pause, abort=1 → core_abort next cycle.
  - mem_rd_en/mem_wr_en are deasserted from that cycle on; a partially written pixel is not completed and pixels_done is not incremented.
  - core_abort lasts 1 cycle, sets aborted, then core_wait_for_start.
  - abort is ignored in other states.
- start is ignored while busy. mode changes mid-run have no effect.
- Addresses are computed modulo 2^ADDR_W. Static check: OUT_BASE+3*IMG_PIXELS-1 < 2^ADDR_W.

Optional Feature:
- Macro: CORE_CYCLE_CNT_EN
- With it:
  - output cycle_cnt (32 bits) is cleared at start and increments every cycle in core_processing or core_pause.
  - It freezes in core_done or core_abort and saturates at 2^32-1.
- Without it: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- mode0, num_pixels=2, pixels (30,60,90),(255,255,254) → writes 60,60,60 then 254,254,254 to OUT_BASE..+5; done after 14 processing cycles; pixels_done=2.
- mode2, pixel (255,255,255) → gray 255 (no overflow). mode1, pixel (10,200,50) → 105. mode3, pixel (1,2,3) → 2.
- num_pixels=0 → core_done one cycle after start, no strobes. num_pixels=IMG_PIXELS+5 → exactly IMG_PIXELS pixels written, last write at OUT_BASE+3*IMG_PIXELS-1.
- pause asserted during P2 of pixel 0, held 10 cycles → pixel 0's three writes complete, 10 idle cycles in core_pause, pixel 1 P0 starts the cycle after pause drops.
- abort during P5 of pixel 3 → no P6 write, pixels_done=3, aborted=1, state core_abort for 1 cycle then core_wait_for_start. The next start clears aborted.
- rst_n driven low mid-P4 → outputs zero asynchronously, state=core_reset. After release, core_wait_for_start next cycle. With CORE_CYCLE_CNT_EN, a 3-pixel run gives cycle_cnt=21.
